if_stage: RTL and testbench

Instruction fetch stage of the multi-state RV32I core, directly downstream of the PC stage. When the sequencer enters the IF state, the block takes the word address `pc` and fetches one 32-bit instruction over a request/acknowledge instruction bus. It presents the instruction and its PC to the decode stage, and reports completion or an instruction access fault. A one-entry last-fetch buffer lets a re-fetch of the same address skip the bus.

---
 rtl/if_stage.sv | 163 ++++++++++++++++
 tb/tb_if_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: fetches one word per IF strobe over a req/ack bus,
// with a one-entry last-fetch buffer, range check and ack timeout.
module if_stage #(
  parameter logic [29:0] IMEM_BASE  = 30'h0000_0000,
  parameter logic [29:0] IMEM_WORDS = 30'd16384,
  parameter logic [3:0]  TIMEOUT    = 4'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_start,
  input  logic        cpu_stat_if,
  input  logic [31:2] pc,
  input  logic        fence_i,
  input  logic        imem_wr,
  output logic        i_req,
  output logic [31:2] i_adr,
  input  logic        i_ack,
  input  logic [31:0] i_rdata,
  output logic [31:0] inst_id,
  output logic [31:2] pc_id,
  output logic        if_done,
  output logic        if_fault,
  output logic        if_busy
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        i_req_q, i_req_d;
  logic [31:2] i_adr_q, i_adr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:2] pc_id_q, pc_id_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:2] buf_adr_q, buf_adr_d;
  logic [31:0] buf_data_q, buf_data_d;

  // 31-bit compare so BASE+WORDS cannot wrap past the top of the address space.
  logic [30:0] pc_ext, base_ext, lim_ext;
  logic        out_of_range, buf_hit;

  assign pc_ext       = {1'b0, pc};
  assign base_ext     = {1'b0, IMEM_BASE};
  assign lim_ext      = base_ext + {1'b0, IMEM_WORDS};
  assign out_of_range = (pc_ext < base_ext) || (pc_ext >= lim_ext);
  assign buf_hit      = buf_valid_q && (pc == buf_adr_q);

  always_comb begin
    state_d     = state_q;
    i_req_d     = i_req_q;
    i_adr_d     = i_adr_q;
    inst_d      = inst_q;
    pc_id_d     = pc_id_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    cnt_d       = cnt_q;
    buf_valid_d = buf_valid_q;
    buf_adr_d   = buf_adr_q;
    buf_data_d  = buf_data_q;

    if (cpu_start) begin
      state_d = S_IDLE;
      i_req_d = 1'b0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_stat_if) begin
            if (out_of_range) begin
              state_d = S_DONE;
              inst_d  = NOP;
              pc_id_d = pc;
              done_d  = 1'b1;
              fault_d = 1'b1;
            end else if (buf_hit) begin
              state_d = S_DONE;
              inst_d  = buf_data_q;
              pc_id_d = pc;
              done_d  = 1'b1;
            end else begin
              state_d = S_WAIT;
              i_req_d = 1'b1;
              i_adr_d = pc;
              cnt_d   = 4'd0;
            end
          end
        end
        S_WAIT: begin
          if (i_ack && i_req_q) begin
            state_d     = S_DONE;
            inst_d      = i_rdata;
            pc_id_d     = i_adr_q;
            buf_adr_d   = i_adr_q;
            buf_data_d  = i_rdata;
            buf_valid_d = 1'b1;
            i_req_d     = 1'b0;
            done_d      = 1'b1;
          end else if (cnt_q == TIMEOUT) begin
            state_d = S_DONE;
            i_req_d = 1'b0;
            inst_d  = NOP;
            pc_id_d = i_adr_q;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Invalidate beats a same-cycle capture so stale code is never served.
    if (fence_i || imem_wr) buf_valid_d = 1'b0;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_req_q     <= 1'b0;
      i_adr_q     <= '0;
      inst_q      <= NOP;
      pc_id_q     <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= 4'd0;
      buf_valid_q <= 1'b0;
      buf_adr_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      i_req_q     <= i_req_d;
      i_adr_q     <= i_adr_d;
      inst_q      <= inst_d;
      pc_id_q     <= pc_id_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
      buf_adr_q   <= buf_adr_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign i_req    = i_req_q;
  assign i_adr    = i_adr_q;
  assign inst_id  = inst_q;
  assign pc_id    = pc_id_q;
  assign if_done  = done_q;
  assign if_fault = fault_q;
  assign if_busy  = busy_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: bus fetch, buffer hit/invalidate, range fault,
// timeout, abort and asynchronous reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_start = 1'b0;
  logic        cpu_stat_if = 1'b0;
  logic [31:2] pc = '0;
  logic        fence_i = 1'b0;
  logic        imem_wr = 1'b0;
  logic        i_req;
  logic [31:2] i_adr;
  logic        i_ack = 1'b0;
  logic [31:0] i_rdata = '0;
  logic [31:0] inst_id;
  logic [31:2] pc_id;
  logic        if_done;
  logic        if_fault;
  logic        if_busy;

  int n_checks = 0;
  int n_pass   = 0;

  if_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_start  (cpu_start),
    .cpu_stat_if(cpu_stat_if),
    .pc         (pc),
    .fence_i    (fence_i),
    .imem_wr    (imem_wr),
    .i_req      (i_req),
    .i_adr      (i_adr),
    .i_ack      (i_ack),
    .i_rdata    (i_rdata),
    .inst_id    (inst_id),
    .pc_id      (pc_id),
    .if_done    (if_done),
    .if_fault   (if_fault),
    .if_busy    (if_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-20s got %0h", tag, obs);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe in cycle 0; returns at the sample point of cycle 1.
  task automatic strobe(input logic [31:2] a);
    pc = a;
    cpu_stat_if = 1'b1;
    tick();
    cpu_stat_if = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] d);
    i_ack = 1'b1;
    i_rdata = d;
    tick();
    i_ack = 1'b0;
  endtask

  initial begin
    int req_cycles;
    logic seen_done;

    repeat (3) tick();
    chk("rst_i_req",   i_req,    0);
    chk("rst_i_adr",   i_adr,    0);
    chk("rst_inst_id", inst_id,  64'h13);
    chk("rst_pc_id",   pc_id,    0);
    chk("rst_if_done", if_done,  0);
    chk("rst_if_fault",if_fault, 0);
    chk("rst_if_busy", if_busy,  0);
    rst_n = 1'b1;
    tick();

    // Reset while a request is outstanding
    strobe(30'h3);
    chk("pre_rst_req", i_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_i_req", i_req, 0);
    chk("midrst_busy",  if_busy, 0);
    chk("midrst_i_adr", i_adr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    strobe(30'h3);
    chk("restart_req", i_req, 1);
    chk("restart_adr", i_adr, 30'h3);
    ack_now(32'hAAAA_0001);
    chk("zw_done", if_done, 1);
    chk("zw_inst", inst_id, 32'hAAAA_0001);
    chk("zw_pc_id", pc_id, 30'h3);
    tick();
    chk("zw_done_pulse", if_done, 0);
    chk("zw_busy_off", if_busy, 0);

    // Bus fetch, ack in cycle 3
    strobe(30'h10);
    tick();
    tick();
    chk("f10_wait_done", if_done, 0);
    chk("f10_wait_req", i_req, 1);
    ack_now(32'h0050_0093);
    chk("f10_done", if_done, 1);
    chk("f10_inst", inst_id, 32'h0050_0093);
    chk("f10_pc_id", pc_id, 30'h10);
    chk("f10_fault", if_fault, 0);
    chk("f10_busy", if_busy, 1);
    tick();

    // Buffer hit, then fence_i forces a bus fetch
    strobe(30'h10);
    chk("hit_done", if_done, 1);
    chk("hit_req", i_req, 0);
    chk("hit_inst", inst_id, 32'h0050_0093);
    tick();
    fence_i = 1'b1;
    tick();
    fence_i = 1'b0;
    strobe(30'h10);
    chk("fence_miss_req", i_req, 1);
    ack_now(32'h1111_1111);
    chk("fence_miss_inst", inst_id, 32'h1111_1111);
    tick();

    // First illegal address
    strobe(30'd16384);
    chk("oor_done", if_done, 1);
    chk("oor_fault", if_fault, 1);
    chk("oor_inst", inst_id, 32'h13);
    chk("oor_pc_id", pc_id, 30'd16384);
    chk("oor_req", i_req, 0);
    tick();

    // Timeout
    strobe(30'h20);
    req_cycles = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i_req) req_cycles++;
      tick();
    end
    chk("to_req_cycles", req_cycles, 16);
    chk("to_req_off", i_req, 0);
    chk("to_done", if_done, 1);
    chk("to_fault", if_fault, 1);
    chk("to_inst", inst_id, 32'h13);
    chk("to_pc_id", pc_id, 30'h20);
    tick();

    // Abort coinciding with ack
    strobe(30'h30);
    ack_now(32'h2222_2222);
    chk("f30_inst", inst_id, 32'h2222_2222);
    tick();
    strobe(30'h40);
    tick();
    cpu_start = 1'b1;
    ack_now(32'h3333_3333);
    cpu_start = 1'b0;
    chk("abort_req", i_req, 0);
    chk("abort_busy", if_busy, 0);
    chk("abort_done", if_done, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (if_done) seen_done = 1'b1;
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_inst", inst_id, 32'h2222_2222);
    strobe(30'h30);
    chk("abort_buf_hit", if_done, 1);
    chk("abort_buf_req", i_req, 0);
    tick();
    strobe(30'h40);
    chk("abort_40_miss", i_req, 1);
    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    tick();

    // Invalidate wins over a same-cycle capture
    strobe(30'h50);
    fence_i = 1'b1;
    ack_now(32'h4444_4444);
    fence_i = 1'b0;
    chk("inv_ack_inst", inst_id, 32'h4444_4444);
    tick();
    strobe(30'h50);
    chk("inv_ack_miss", i_req, 1);
    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    chk("inv_abort_req", i_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
